// File: rtl/seq_mean_divider.sv
// Multi-cycle radix-2 restoring unsigned divider for cluster-mean computation.
// One quotient bit per enabled cycle; start/busy/done handshake with optional rounding.
module seq_mean_divider #(
  parameter int DIVIDEND_W = 20,
  parameter int DIVISOR_W  = 12,
  parameter int ROUND      = 0
) (
  input  logic                  clk,
  input  logic                  sclr,
  input  logic                  ce,
  input  logic                  en,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  busy,
  output logic                  done,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_by_zero
);

  localparam int CW = $clog2(DIVIDEND_W);

  typedef enum logic [1:0] {IDLE, CALC, FIN, DONE} state_t;

  state_t state, state_nx;

  logic                  adv;
  logic [CW-1:0]         cnt;
  logic [DIVIDEND_W-1:0] dvd;
  logic [DIVISOR_W-1:0]  dsr;
  logic [DIVISOR_W-1:0]  part;
  logic [DIVISOR_W:0]    trial;
  logic [DIVISOR_W-1:0]  diff;
  logic                  ge;
  logic                  rnd_up;
  logic [DIVIDEND_W-1:0] q_fin;

  assign adv   = ce & en;
  assign busy  = (state == CALC) || (state == FIN);
  assign done  = (state == DONE);

  // dvd shifts out dividend bits at the top and collects quotient bits at the bottom
  assign trial = {part, dvd[DIVIDEND_W-1]};
  assign ge    = trial >= {1'b0, dsr};
  assign diff  = trial[DIVISOR_W-1:0] - dsr;

  assign rnd_up = (ROUND != 0) && ({part, 1'b0} >= {1'b0, dsr});
  assign q_fin  = (rnd_up && !(&dvd)) ? dvd + DIVIDEND_W'(1) : dvd;

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (start) state_nx = (divisor == '0) ? DONE : CALC;
      CALC: if (cnt == '0) state_nx = FIN;
      FIN:  state_nx = DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (sclr) begin
      state <= IDLE;
    end else if (adv) begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (sclr) begin
      cnt         <= '0;
      dvd         <= '0;
      dsr         <= '0;
      part        <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (adv) begin
      unique case (state)
        IDLE: begin
          if (start) begin
            if (divisor == '0) begin
              quotient    <= '1;
              remainder   <= '0;
              div_by_zero <= 1'b1;
            end else begin
              dvd  <= dividend;
              dsr  <= divisor;
              part <= '0;
              cnt  <= CW'(DIVIDEND_W - 1);
            end
          end
        end
        CALC: begin
          part <= ge ? diff : trial[DIVISOR_W-1:0];
          dvd  <= {dvd[DIVIDEND_W-2:0], ge};
          if (cnt != '0) cnt <= cnt - 1'b1;
        end
        FIN: begin
          quotient  <= q_fin;
          remainder <= part;
        end
        DONE: div_by_zero <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule
